// File: rtl/a2d_pkg.sv
// Shared definitions for the ADC round-robin sequencer and its SPI master.
package a2d_pkg;

  // ADC channel numbers for each measured quantity
  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  // Sequencer: every channel is converted twice, the second frame carries the result
  typedef enum logic [1:0] {IDLE, CNV1, GAP, CNV2} seq_state_t;

  // SPI master: shifting 16 bits, then the half-period tail before SS_n rises
  typedef enum logic [1:0] {SPI_IDLE, SPI_SHIFT, SPI_TAIL} spi_state_t;

  // Round-robin slot (0..3) to physical ADC channel
  function automatic logic [2:0] slot_to_chnl(input logic [1:0] slot);
    case (slot)
      2'd0:    return CH_LFT;
      2'd1:    return CH_RGHT;
      2'd2:    return CH_STEER;
      default: return CH_BATT;
    endcase
  endfunction

  // ADC command word selecting a channel
  function automatic logic [15:0] chnl_cmd(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_intf_spi.sv
// 16-bit SPI master: SCLK idles high, low half then high half per bit,
// MOSI updates on SCLK fall, MISO sampled on SCLK rise, MSB first.
module spi_mstr16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int DW = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] HALF_LAST = DW'(SCLK_DIV / 2 - 1);
  localparam logic [DW-1:0] FULL_LAST = DW'(SCLK_DIV - 1);

  spi_state_t    state_reg, state_next;
  logic [DW-1:0] div_cnt_reg;
  logic [3:0]    bit_cnt_reg;
  logic [15:0]   tx_reg, rx_reg;
  logic          ss_n_reg, sclk_reg, done_reg;
  logic          start, rise, fall, finish;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= SPI_IDLE;
    else        state_reg <= state_next;
  end

  // Next state and per-cycle SCLK edge strobes
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      SPI_IDLE: begin
        if (wrt) begin
          start      = 1'b1;
          state_next = SPI_SHIFT;
        end
      end
      SPI_SHIFT: begin
        if (div_cnt_reg == HALF_LAST) rise = 1'b1;
        if (div_cnt_reg == FULL_LAST) begin
          // after the 16th high half SCLK simply stays high
          if (bit_cnt_reg == 4'd15) state_next = SPI_TAIL;
          else                      fall = 1'b1;
        end
      end
      SPI_TAIL: begin
        if (div_cnt_reg == HALF_LAST) begin
          finish     = 1'b1;
          state_next = SPI_IDLE;
        end
      end
      default: state_next = SPI_IDLE;
    endcase
  end

  // Datapath: divider, bit counter, shift registers and pin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      ss_n_reg    <= 1'b1;
      sclk_reg    <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= finish;
      if (start) begin
        ss_n_reg    <= 1'b0;
        sclk_reg    <= 1'b0;
        div_cnt_reg <= '0;
        bit_cnt_reg <= '0;
        tx_reg      <= cmd;
      end else if (state_reg != SPI_IDLE) begin
        if (state_reg == SPI_SHIFT && div_cnt_reg == FULL_LAST) div_cnt_reg <= '0;
        else                                                    div_cnt_reg <= div_cnt_reg + DW'(1);
        if (rise) begin
          sclk_reg <= 1'b1;
          rx_reg   <= {rx_reg[14:0], MISO};
        end
        if (fall) begin
          sclk_reg    <= 1'b0;
          tx_reg      <= {tx_reg[14:0], 1'b0};
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
        if (finish) ss_n_reg <= 1'b1;
      end
    end
  end

  assign SS_n    = ss_n_reg;
  assign SCLK    = sclk_reg;
  assign MOSI    = ~ss_n_reg & tx_reg[15];
  assign done    = done_reg;
  assign rd_data = rx_reg;

endmodule

// File: rtl/a2d_intf.sv
// Round-robin ADC sequencer: each nxt converts the next of ch0/ch4/ch5/ch6
// (two SPI frames, result taken from the second) into its holding register.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        rnd_cmplt
);

  seq_state_t  state_reg, state_next;
  logic [1:0]  slot_reg;
  logic        rnd_cmplt_reg;
  logic        wrt, upd, done;
  logic [15:0] cmd, rd_data;
  logic        rd_unused;

  // The same command is sent in both frames of a conversion
  assign cmd = chnl_cmd(slot_to_chnl(slot_reg));

  // The response's upper nibble carries no result bits
  assign rd_unused = ^rd_data[15:12];

  spi_mstr16 #(.SCLK_DIV(SCLK_DIV)) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Sequencer next state; nxt is only honoured in IDLE
  always_comb begin
    state_next = state_reg;
    wrt        = 1'b0;
    upd        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (nxt) begin
          wrt        = 1'b1;
          state_next = CNV1;
        end
      end
      CNV1: if (done) state_next = GAP;
      GAP: begin
        wrt        = 1'b1;
        state_next = CNV2;
      end
      CNV2: begin
        if (done) begin
          upd        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slot pointer advance and end-of-round strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg      <= 2'd0;
      rnd_cmplt_reg <= 1'b0;
    end else begin
      rnd_cmplt_reg <= upd && (slot_reg == 2'd3);
      if (upd) slot_reg <= slot_reg + 2'd1;
    end
  end

  // One holding register per slot, loaded when its conversion completes
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    logic [11:0] res_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             res_reg <= 12'h000;
      else if (upd && slot_reg == 2'(gi))     res_reg <= rd_data[11:0];
    end
  end

  assign lft_ld    = g_slot[0].res_reg;
  assign rght_ld   = g_slot[1].res_reg;
  assign steer_pot = g_slot[2].res_reg;
  assign batt      = g_slot[3].res_reg;
  assign rnd_cmplt = rnd_cmplt_reg;

endmodule

// File: doc/a2d_intf.md
Name: a2d_intf

Overview:
- Round-robin sequencer for the 8-channel serial ADC that supplies lft_ld, rght_ld, steer_pot and batt.
- Each nxt pulse converts one channel over SPI and updates that channel's holding register.
- Sits directly upstream of steer_en (lft_ld, rght_ld) and the steering/battery logic.
- Contains one 16-bit SPI master sub-module.

Parameters:
SCLK_DIV, 32, clk cycles per SCLK period; even, >=4 (32 gives 1.5625 MHz at 50 MHz)

Ports:
clk  input  1  50 MHz system clock
rst_n  input  1  asynchronous active-low reset
nxt  input  1  one-clk pulse requesting the next channel conversion
MISO  input  1  ADC serial data out
SS_n  output  1  ADC chip select, active low
SCLK  output  1  SPI clock, idles high
MOSI  output  1  ADC serial data in
lft_ld  output  12  left load cell result (ADC ch0)
rght_ld  output  12  right load cell result (ADC ch4)
steer_pot  output  12  steering pot result (ADC ch5)
batt  output  12  battery voltage result (ADC ch6)
rnd_cmplt  output  1  one-clk pulse when batt is updated (full round done)

Behaviour:
- Reset values: all four result registers 12'h000; rnd_cmplt 0; SS_n 1; SCLK 1; MOSI 0. Round-robin pointer = lft_ld slot.
- Round-robin order: lft_ld(ch0) -> rght_ld(ch4) -> steer_pot(ch5) -> batt(ch6) -> lft_ld. 2-bit pointer wraps 3->0.
- Command word: {2'b00, chnl[2:0], 11'h000}.
- Sequencer states: IDLE, CNV1, GAP, CNV2.
  - IDLE: on nxt, assert wrt to the SPI master with the command; go to CNV1.
  - CNV1: wait for done; ignore the response; go to GAP.
  - GAP: exactly 1 clk; assert wrt with the same command; go to CNV2.
  - CNV2: on done, load rd_data[11:0] into the selected register; advance the pointer; pulse rnd_cmplt if the slot was batt; go to IDLE.
- Result register updates the clk after done. Other registers hold.
- nxt outside IDLE is ignored, not queued.
- SPI master, spi_mstr16:
  - wrt starts a transaction. SS_n falls the clk after wrt.
  - 16 SCLK periods, MSB first. SCLK low half, then high half.
  - MOSI changes on SCLK fall. MISO sampled at the SCLK rise edge into a 16-bit shift register.
  - After the 16th rise: SCLK returns high, SS_n rises half a period later, done pulses 1 clk coincident with SS_n rising.
  - rd_data is valid from done until the next wrt.
  - wrt while busy is ignored.
- Timing: one conversion = 2 x (16 x SCLK_DIV + ~SCLK_DIV) + small overhead, about 1.1k clk at the default.
- Reset mid-transaction: SS_n immediately 1, SCLK 1, pointer and registers cleared, sequencer IDLE. The partial conversion is discarded.

Decomposition:
- Shared package a2d_pkg:
  - channel constants CH_LFT=3'd0, CH_RGHT=3'd4, CH_STEER=3'd5, CH_BATT=3'd6
  - typedef enum of sequencer states
  - slot index to channel mapping function
- Sub-module spi_mstr16 (clk, rst_n, wrt, cmd[15:0], done, rd_data[15:0], SS_n, SCLK, MOSI, MISO), parameter SCLK_DIV.

Test Plan:
1. Reset, no nxt, 10k clk -> SS_n=1, SCLK=1, all results 0, rnd_cmplt never asserted.
2. ADC model returns 12'hA5C for ch0; one nxt -> two SS_n frames; both MOSI words 16'h0000; lft_ld=12'hA5C; other outputs 0.
3. Model per-channel values ch0=12'h300, ch4=12'h120, ch5=12'h7FF, ch6=12'hC00; four nxt pulses -> all four registers match.
   - MOSI words in order 0000, 2000, 2800, 3000.
   - rnd_cmplt pulses once, after the batt update.
4. Fifth nxt -> re-reads ch0 (pointer wrap); lft_ld updated, others unchanged.
5. nxt pulsed again during CNV1 -> ignored; only one conversion; pointer advances by exactly 1.
6. rst_n asserted mid-CNV2 -> SS_n high within the same cycle; results 0; the next nxt converts ch0.
